// File: rtl/control_pkg.sv
// Shared encodings for the RV32I multicycle/single-cycle controllers:
// FSM states, opcodes, ALU codes and datapath mux selects.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from ALUOp and instruction fields.
// Shared between the single-cycle and multicycle controllers.
module alu_decoder
  import control_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          // only R-type (op5=1) can encode sub; addi with imm[10]=1 stays add
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle RV32I datapath: Moore FSM sequencing
// the shared memory/ALU muxes, plus ALU and immediate decode.
module multicycle_control_fsm
  import control_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       IllegalOp,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_write_raw, reg_write_raw, mem_write_raw, illegal_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    AdrSrc        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_WD;
    ResultSrc     = RES_ALUOUT;
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    illegal_raw   = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d      = S_DECODE;
        ir_write_raw = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURES;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BRANCH:    state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        state_d = S_ALUWB;
        ALUSrcA = SRCA_A;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        state_d = S_ALUWB;
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_A;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        state_d   = S_ALUWB;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // funct3[0] flips the zero test so one state serves both beq and bne
  assign PCWrite   = ~reset & (pc_update | (branch & (zero ^ funct3[0])));
  assign IRWrite   = ~reset & ir_write_raw;
  assign RegWrite  = ~reset & reg_write_raw;
  assign MemWrite  = ~reset & mem_write_raw;
  assign IllegalOp = ~reset & illegal_raw;
  assign state     = state_q;

  always_comb begin
    case (op)
      OP_SW:     ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_dec (
    .ALUOp      (alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench: stimulus pushes hand-computed expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       AdrSrc, PCWrite, IRWrite, RegWrite, MemWrite, IllegalOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  typedef struct {
    string       name;
    logic [20:0] v;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [9:0] ctl_tab [0:10];

  multicycle_control_fsm #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .AdrSrc(AdrSrc), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .IllegalOp(IllegalOp), .state(state)
  );

  always #5 clk = ~clk;

  // Monitor: one expected vector per cycle, sampled mid-cycle
  initial begin
    logic [20:0] act;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {state, AdrSrc, PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl, ImmSrc, IllegalOp};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                   e.name, act, e.v, act[20:17], e.v[20:17]);
        end
      end
    end
  end

  // One cycle: drive inputs after the edge, push the outputs the spec requires
  task automatic step(input string nm, input bit rst, input logic [6:0] o,
                      input logic [2:0] f3, input bit f7, input bit z,
                      input logic [3:0] st, input logic [2:0] alu,
                      input logic [1:0] imm, input bit pcw, input bit ill);
    exp_t       e;
    logic [9:0] c;
    @(posedge clk);
    #1;
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z;
    c = ctl_tab[st];
    if (rst) c[8:6] = 3'b000;
    e.name = nm;
    e.v    = {st, c[9], pcw, c[8], c[7], c[6], c[5:0], alu, imm, ill};
    sb.push_back(e);
  endtask

  task automatic run_alu(input string nm, input logic [6:0] o, input logic [2:0] f3,
                         input bit f7, input logic [3:0] exec_st, input logic [2:0] alu);
    step({nm, "_fetch"},  0, o, f3, f7, 0, 4'd0, 3'b000, 2'b00, 1, 0);
    step({nm, "_decode"}, 0, o, f3, f7, 0, 4'd1, 3'b000, 2'b00, 0, 0);
    step({nm, "_exec"},   0, o, f3, f7, 0, exec_st, alu, 2'b00, 0, 0);
    step({nm, "_aluwb"},  0, o, f3, f7, 0, 4'd8, 3'b000, 2'b00, 0, 0);
  endtask

  task automatic run_br(input string nm, input logic [2:0] f3, input bit z, input bit pcw);
    step({nm, "_fetch"},  0, BR, f3, 0, z, 4'd0, 3'b000, 2'b10, 1, 0);
    step({nm, "_decode"}, 0, BR, f3, 0, z, 4'd1, 3'b000, 2'b10, 0, 0);
    step({nm, "_beq"},    0, BR, f3, 0, z, 4'd9, 3'b001, 2'b10, pcw, 0);
  endtask

  initial begin
    // {AdrSrc, IRWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ResultSrc}
    ctl_tab = '{10'b0_1_0_0_00_10_10,   // FETCH
                10'b0_0_0_0_01_01_00,   // DECODE
                10'b0_0_0_0_10_01_00,   // MEMADR
                10'b1_0_0_0_00_00_00,   // MEMREAD
                10'b0_0_1_0_00_00_01,   // MEMWB
                10'b1_0_0_1_00_00_00,   // MEMWRITE
                10'b0_0_0_0_10_00_00,   // EXECUTER
                10'b0_0_0_0_10_01_00,   // EXECUTEI
                10'b0_0_1_0_00_00_00,   // ALUWB
                10'b0_0_0_0_10_00_00,   // BEQ
                10'b0_0_0_0_01_10_00};  // JAL
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);

    // reset holds FETCH with write enables forced low
    step("rst_hold",   1, SW, 0, 0, 0, 4'd0, 3'b000, 2'b01, 0, 0);
    // sw in flight, reset asserted in MEMWRITE
    step("sw_fetch",   0, SW, 0, 0, 0, 4'd0, 3'b000, 2'b01, 1, 0);
    step("sw_decode",  0, SW, 0, 0, 0, 4'd1, 3'b000, 2'b01, 0, 0);
    step("sw_memadr",  0, SW, 0, 0, 0, 4'd2, 3'b000, 2'b01, 0, 0);
    step("sw_memwr_rst", 1, SW, 0, 0, 0, 4'd5, 3'b000, 2'b01, 0, 0);
    // lw: 0,1,2,3,4
    step("lw_fetch",   0, LW, 0, 0, 0, 4'd0, 3'b000, 2'b00, 1, 0);
    step("lw_decode",  0, LW, 0, 0, 0, 4'd1, 3'b000, 2'b00, 0, 0);
    step("lw_memadr",  0, LW, 0, 0, 0, 4'd2, 3'b000, 2'b00, 0, 0);
    step("lw_memread", 0, LW, 0, 0, 0, 4'd3, 3'b000, 2'b00, 0, 0);
    step("lw_memwb",   0, LW, 0, 0, 0, 4'd4, 3'b000, 2'b00, 0, 0);
    // full sw without reset
    step("sw2_fetch",  0, SW, 0, 0, 0, 4'd0, 3'b000, 2'b01, 1, 0);
    step("sw2_decode", 0, SW, 0, 0, 0, 4'd1, 3'b000, 2'b01, 0, 0);
    step("sw2_memadr", 0, SW, 0, 0, 0, 4'd2, 3'b000, 2'b01, 0, 0);
    step("sw2_memwr",  0, SW, 0, 0, 0, 4'd5, 3'b000, 2'b01, 0, 0);
    // ALU decode through R and I types
    run_alu("r_sub", RT, 3'b000, 1, 4'd6, 3'b001);
    run_alu("r_add", RT, 3'b000, 0, 4'd6, 3'b000);
    run_alu("r_and", RT, 3'b111, 0, 4'd6, 3'b010);
    run_alu("r_or",  RT, 3'b110, 0, 4'd6, 3'b011);
    run_alu("i_add_f7", IT, 3'b000, 1, 4'd7, 3'b000);
    run_alu("i_slt", IT, 3'b010, 0, 4'd7, 3'b101);
    run_alu("i_xor", IT, 3'b100, 0, 4'd7, 3'b000);
    // beq / bne
    run_br("beq_taken", 3'b000, 1, 1);
    run_br("beq_not",   3'b000, 0, 0);
    run_br("bne_taken", 3'b001, 0, 1);
    run_br("bne_not",   3'b001, 1, 0);
    // jal: 0,1,10,8
    step("jal_fetch",  0, JL, 0, 0, 0, 4'd0,  3'b000, 2'b11, 1, 0);
    step("jal_decode", 0, JL, 0, 0, 0, 4'd1,  3'b000, 2'b11, 0, 0);
    step("jal_jal",    0, JL, 0, 0, 0, 4'd10, 3'b000, 2'b11, 1, 0);
    step("jal_aluwb",  0, JL, 0, 0, 0, 4'd8,  3'b000, 2'b11, 0, 0);
    // illegal opcode: one-cycle IllegalOp, straight back to FETCH
    step("ill_fetch",  0, 7'b0000000, 0, 0, 0, 4'd0, 3'b000, 2'b00, 1, 0);
    step("ill_decode", 0, 7'b0000000, 0, 0, 0, 4'd1, 3'b000, 2'b00, 0, 1);
    step("ill_refetch", 0, LW, 0, 0, 0, 4'd0, 3'b000, 2'b00, 1, 0);
    step("ill_next",   0, LW, 0, 0, 0, 4'd1, 3'b000, 2'b00, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
